// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the load/store path: XLEN, funct3 width codes,
// the LSU state encoding and the byte-enable helper.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_t;

    // Byte lanes touched by an access of the given size at a lane offset.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a 32-bit load word.
module load_align
    import rv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Move the addressed lane down to bit 0, then extend per funct3.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'h000000, shifted[7:0]};
            F3_HU:   result = {16'h0000, shifted[15:0]};
            F3_W:    result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between exec and writeback with a req/gnt/rvalid data bus.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned accesses into a one-cycle trap.
module lsu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_exec_out,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic              in_rd_write_enable,
    input  logic [4:0]        in_rd_addr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [3:0]        bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              wb_valid,
    output logic              wb_rd_write_enable,
    output logic [4:0]        wb_rd_addr,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              misaligned_exc,
`endif
    output logic [XLEN-1:0]   wb_data
);

    lsu_state_t  state;
    logic        lat_is_store;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic        lat_rd_we;
    logic [4:0]  lat_rd_addr;

    logic        is_mem;
    logic        trap;
    logic [1:0]  eff_off;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] load_result;

    assign in_ready = (state == ST_IDLE);

    // Decode the incoming bundle into the request it would issue.
    always_comb begin
        is_mem = in_is_load | in_is_store;
        case (in_funct3[1:0])
            2'b01:   eff_off = {in_exec_out[1], 1'b0};
            2'b10:   eff_off = 2'b00;
            default: eff_off = in_exec_out[1:0];
        endcase
        case (in_funct3[1:0])
            2'b00:   req_wdata = {4{in_store_data[7:0]}};
            2'b01:   req_wdata = {2{in_store_data[15:0]}};
            default: req_wdata = in_store_data;
        endcase
        req_be = byte_enable(in_funct3[1:0], eff_off);
`ifdef LSU_MISALIGN_TRAP_EN
        case (in_funct3[1:0])
            2'b01:   trap = is_mem & in_exec_out[0];
            2'b10:   trap = is_mem & (in_exec_out[1:0] != 2'b00);
            default: trap = 1'b0;
        endcase
`else
        trap = 1'b0;
`endif
    end

    load_align u_load_align (
        .rdata  (bus_rdata),
        .off    (lat_off),
        .funct3 (lat_funct3),
        .result (load_result)
    );

    // Transaction FSM with registered bus and MEM/WB outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            lat_is_store       <= 1'b0;
            lat_funct3         <= 3'b000;
            lat_off            <= 2'b00;
            lat_rd_we          <= 1'b0;
            lat_rd_addr        <= 5'd0;
            bus_req            <= 1'b0;
            bus_we             <= 1'b0;
            bus_addr           <= '0;
            bus_be             <= 4'b0000;
            bus_wdata          <= '0;
            wb_valid           <= 1'b0;
            wb_rd_write_enable <= 1'b0;
            wb_rd_addr         <= 5'd0;
            wb_data            <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_exc     <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_exc <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (in_valid && trap) begin
                        wb_valid           <= 1'b1;
                        wb_rd_write_enable <= 1'b0;
                        wb_rd_addr         <= in_rd_addr;
                        wb_data            <= in_exec_out;
`ifdef LSU_MISALIGN_TRAP_EN
                        misaligned_exc     <= 1'b1;
`endif
                    end else if (in_valid && is_mem) begin
                        lat_is_store <= in_is_store;
                        lat_funct3   <= in_funct3;
                        lat_off      <= eff_off;
                        lat_rd_we    <= in_rd_write_enable & in_is_load;
                        lat_rd_addr  <= in_rd_addr;
                        bus_req      <= 1'b1;
                        bus_we       <= in_is_store;
                        bus_addr     <= {in_exec_out[XLEN-1:2], 2'b00};
                        bus_be       <= req_be;
                        bus_wdata    <= req_wdata;
                        state        <= ST_REQ;
                    end else if (in_valid) begin
                        wb_valid           <= 1'b1;
                        wb_rd_write_enable <= in_rd_write_enable & (in_rd_addr != 5'd0);
                        wb_rd_addr         <= in_rd_addr;
                        wb_data            <= in_exec_out;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        if (lat_is_store) begin
                            wb_valid           <= 1'b1;
                            wb_rd_write_enable <= 1'b0;
                            wb_rd_addr         <= lat_rd_addr;
                            wb_data            <= bus_addr;
                            state              <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        state <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        wb_valid           <= 1'b1;
                        wb_rd_write_enable <= lat_rd_we & (lat_rd_addr != 5'd0);
                        wb_rd_addr         <= lat_rd_addr;
                        wb_data            <= load_result;
                        state              <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    bus_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; exercises the trap path when
// LSU_MISALIGN_TRAP_EN is defined and the truncation path otherwise.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_exec_out, in_store_data;
    logic        in_rd_write_enable;
    logic [4:0]  in_rd_addr;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        wb_valid, wb_rd_write_enable;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misaligned_exc;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_exec_out(in_exec_out),
        .in_store_data(in_store_data),
        .in_rd_write_enable(in_rd_write_enable), .in_rd_addr(in_rd_addr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_rd_write_enable(wb_rd_write_enable),
        .wb_rd_addr(wb_rd_addr),
`ifdef LSU_MISALIGN_TRAP_EN
        .misaligned_exc(misaligned_exc),
`endif
        .wb_data(wb_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
        in_valid           = 1'b1;
        in_is_load         = ld;
        in_is_store        = st;
        in_funct3          = f3;
        in_exec_out        = addr;
        in_store_data      = sdata;
        in_rd_write_enable = 1'b1;
        in_rd_addr         = rd;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input int gnt_delay,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        drive(1'b0, 1'b1, f3, addr, sdata, 5'd7);
        step();
        in_valid = 1'b0;
        check({tag, "_req"}, {31'd0, bus_req}, 32'd1);
        check({tag, "_we"}, {31'd0, bus_we}, 32'd1);
        for (int i = 0; i < gnt_delay; i++) begin
            check({tag, "_addr"}, bus_addr, exp_addr);
            check({tag, "_be"}, {28'd0, bus_be}, {28'd0, exp_be});
            check({tag, "_wdata"}, bus_wdata, exp_wdata);
            check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_wbv_wait"}, {31'd0, wb_valid}, 32'd0);
            step();
        end
        check({tag, "_req_held"}, {31'd0, bus_req}, 32'd1);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        check({tag, "_wbwe"}, {31'd0, wb_rd_write_enable}, 32'd0);
        check({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
        step();
        check({tag, "_wbv_once"}, {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_data, input logic exp_we);
        drive(1'b1, 1'b0, f3, addr, 32'h0, rd);
        step();
        in_valid = 1'b0;
        check({tag, "_req"}, {31'd0, bus_req}, 32'd1);
        check({tag, "_we"}, {31'd0, bus_we}, 32'd0);
        check({tag, "_addr"}, bus_addr, exp_addr);
        check({tag, "_be"}, {28'd0, bus_be}, {28'd0, exp_be});
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        check({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
        step();
        check({tag, "_wbv_wait"}, {31'd0, wb_valid}, 32'd0);
        check({tag, "_ready_wait"}, {31'd0, in_ready}, 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        step();
        bus_rvalid = 1'b0;
        check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_wbwe"}, {31'd0, wb_rd_write_enable}, {31'd0, exp_we});
        check({tag, "_rd"}, {27'd0, wb_rd_addr}, {27'd0, rd});
        step();
        check({tag, "_wbv_once"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'b000; in_exec_out = 32'h0; in_store_data = 32'h0;
        in_rd_write_enable = 1'b0; in_rd_addr = 5'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        step();
        step();
        check("rst_req", {31'd0, bus_req}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wbv", {31'd0, wb_valid}, 32'd0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_be", {28'd0, bus_be}, 32'd0);
        check("rst_wbdata", wb_data, 32'h0);
        rst = 1'b0;
        step();

        // Non-memory bundle
        drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        step();
        in_valid = 1'b0;
        check("add_wbv", {31'd0, wb_valid}, 32'd1);
        check("add_data", wb_data, 32'h0000_1234);
        check("add_rd", {27'd0, wb_rd_addr}, 32'd5);
        check("add_we", {31'd0, wb_rd_write_enable}, 32'd1);
        check("add_noreq", {31'd0, bus_req}, 32'd0);
        step();
        check("add_once", {31'd0, wb_valid}, 32'd0);

        do_store("sb", 3'b000, 32'h0000_1003, 32'h0000_00AB, 3, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
        do_store("sh", 3'b001, 32'h0000_1002, 32'h1234_BEEF, 0, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF);

        do_load("lb", 3'b000, 32'h0000_2001, 5'd3, 32'h0000_8000, 32'h0000_2000, 4'b0010, 32'hFFFF_FF80, 1'b1);
        do_load("lbu", 3'b100, 32'h0000_2001, 5'd3, 32'h0000_8000, 32'h0000_2000, 4'b0010, 32'h0000_0080, 1'b1);
        do_load("lh", 3'b001, 32'h0000_2002, 5'd4, 32'h8001_0000, 32'h0000_2000, 4'b1100, 32'hFFFF_8001, 1'b1);
        do_load("lhu", 3'b101, 32'h0000_2002, 5'd4, 32'h8001_0000, 32'h0000_2000, 4'b1100, 32'h0000_8001, 1'b1);
        do_load("lw_x0", 3'b010, 32'h0000_2000, 5'd0, 32'h1234_5678, 32'h0000_2000, 4'b1111, 32'h1234_5678, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        drive(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd6);
        step();
        in_valid = 1'b0;
        check("mis_exc", {31'd0, misaligned_exc}, 32'd1);
        check("mis_wbv", {31'd0, wb_valid}, 32'd1);
        check("mis_data", wb_data, 32'h0000_3002);
        check("mis_we", {31'd0, wb_rd_write_enable}, 32'd0);
        check("mis_noreq", {31'd0, bus_req}, 32'd0);
        step();
        check("mis_exc_once", {31'd0, misaligned_exc}, 32'd0);
        check("mis_noreq2", {31'd0, bus_req}, 32'd0);
`else
        do_load("lw_mis", 3'b010, 32'h0000_3002, 5'd6, 32'hCAFE_F00D, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D, 1'b1);
`endif

        // Reset while the request is outstanding drops bus_req at once
        drive(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd9);
        step();
        in_valid = 1'b0;
        check("rreq_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rreq_drop", {31'd0, bus_req}, 32'd0);
        check("rreq_ready", {31'd0, in_ready}, 32'd1);
        step();
        rst = 1'b0;

        // Reset in WAIT, then a late rvalid must not produce writeback
        drive(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd9);
        step();
        in_valid = 1'b0;
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        check("rwait_ready0", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("rwait_ready", {31'd0, in_ready}, 32'd1);
        check("rwait_req", {31'd0, bus_req}, 32'd0);
        step();
        rst = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_BEEF;
        step();
        bus_rvalid = 1'b0;
        check("rwait_nowb", {31'd0, wb_valid}, 32'd0);
        check("rwait_idle", {31'd0, in_ready}, 32'd1);
        step();
        check("rwait_nowb2", {31'd0, wb_valid}, 32'd0);

        // Still functional after the abandoned transaction
        drive(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd0);
        step();
        in_valid = 1'b0;
        check("post_wbv", {31'd0, wb_valid}, 32'd1);
        check("post_data", wb_data, 32'h0000_0055);
        check("post_we_x0", {31'd0, wb_rd_write_enable}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
